// File: rtl/ahb_pkg.sv
// ahb_pkg: AHB encodings shared by the NN calculator bus master and the
// register slave on s_AHBIF, plus the master FSM state type.
package ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [1:0] {
    HRESP_OKAY  = 2'b00,
    HRESP_ERROR = 2'b01,
    HRESP_RETRY = 2'b10,
    HRESP_SPLIT = 2'b11
  } hresp_e;

  localparam logic [2:0] HSIZE_WORD    = 3'b010;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;

  // RUN: normal pipelining. RESP2: second cycle of ERROR/RETRY/SPLIT.
  typedef enum logic {
    MST_RUN   = 1'b0,
    MST_RESP2 = 1'b1
  } mst_state_e;

endpackage

// File: rtl/ahb_cmd_slot.sv
// ahb_cmd_slot: one pipeline slot of the AHB master (address or data phase).
// Holds valid, direction, address, write data and retry count.
// Ports:
//   clk, rst          clock, async active-high reset (slot cleared)
//   load              capture ld_* and set valid (wins over clr)
//   clr               empty the slot, fields zeroed
//   ld_*              values captured on load
//   valid..cnt        current slot contents
module ahb_cmd_slot #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              clr,
  input  logic              ld_write,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  input  logic [CNT_W-1:0]  ld_cnt,
  output logic              valid,
  output logic              write,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] wdata,
  output logic [CNT_W-1:0]  cnt
);

  logic              valid_d, valid_q;
  logic              write_d, write_q;
  logic [ADDR_W-1:0] addr_d,  addr_q;
  logic [DATA_W-1:0] wdata_d, wdata_q;
  logic [CNT_W-1:0]  cnt_d,   cnt_q;

  always_comb begin
    valid_d = valid_q;
    write_d = write_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    if (load) begin
      valid_d = 1'b1;
      write_d = ld_write;
      addr_d  = ld_addr;
      wdata_d = ld_wdata;
      cnt_d   = ld_cnt;
    end else if (clr) begin
      valid_d = 1'b0;
      write_d = 1'b0;
      addr_d  = '0;
      wdata_d = '0;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
    end
  end

  assign valid = valid_q;
  assign write = write_q;
  assign addr  = addr_q;
  assign wdata = wdata_q;
  assign cnt   = cnt_q;

endmodule

// File: rtl/ahb_master.sv
// ahb_master: turns single-word read/write commands into pipelined AHB
// SINGLE/NONSEQ transfers. The next command's address phase overlaps the
// current data phase; wait states and two-cycle ERROR/RETRY/SPLIT are
// handled and one in-order response is returned per command.
// Ports:
//   HCLK, HRESET                  clock, async active-high reset
//   cmd_valid/ready/write/addr/wdata   command handshake
//   rsp_valid/rdata/err           one-cycle response pulse
//   HADDR..HWDATA                 AHB master outputs
//   HRDATA, HREADY, HRESP         AHB slave-side inputs
module ahb_master #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_RETRY = 4
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] HADDR,
  output logic [1:0]        HTRANS,
  output logic              HWRITE,
  output logic [2:0]        HSIZE,
  output logic [2:0]        HBURST,
  output logic [DATA_W-1:0] HWDATA,
  input  logic [DATA_W-1:0] HRDATA,
  input  logic              HREADY,
  input  logic [1:0]        HRESP
);
  import ahb_pkg::*;

  localparam int CNT_W = $clog2(MAX_RETRY + 1);

  mst_state_e        state_d, state_q;
  hresp_e            resp_kind_d, resp_kind_q;
  logic              reissue_d, reissue_q;
  logic              rsp_valid_d, rsp_valid_q;
  logic [DATA_W-1:0] rsp_rdata_d, rsp_rdata_q;
  logic              rsp_err_d, rsp_err_q;

  logic              aph_valid, aph_write;
  logic [ADDR_W-1:0] aph_addr;
  logic [DATA_W-1:0] aph_wdata;
  logic [CNT_W-1:0]  aph_cnt;
  logic              aph_ld, aph_clr;

  logic              dph_valid, dph_write;
  logic [ADDR_W-1:0] dph_addr;
  logic [DATA_W-1:0] dph_wdata;
  logic [CNT_W-1:0]  dph_cnt;
  logic              dph_ld, dph_clr;
  logic              dph_ld_write;
  logic [ADDR_W-1:0] dph_ld_addr;
  logic [DATA_W-1:0] dph_ld_wdata;
  logic [CNT_W-1:0]  dph_ld_cnt;

  logic              accept;

  // APH is "cancelled-pending" implicitly: while in RESP2 or while the DPH
  // command is being re-issued, APH is held and not driven on the bus.
  assign cmd_ready = (state_q == MST_RUN) && !reissue_q &&
                     (!aph_valid || HREADY);
  assign accept    = cmd_valid && cmd_ready;

  ahb_cmd_slot #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) u_aph (
    .clk      (HCLK),
    .rst      (HRESET),
    .load     (aph_ld),
    .clr      (aph_clr),
    .ld_write (cmd_write),
    .ld_addr  (cmd_addr & ~ADDR_W'(3)),
    .ld_wdata (cmd_wdata),
    .ld_cnt   ('0),
    .valid    (aph_valid),
    .write    (aph_write),
    .addr     (aph_addr),
    .wdata    (aph_wdata),
    .cnt      (aph_cnt)
  );

  ahb_cmd_slot #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) u_dph (
    .clk      (HCLK),
    .rst      (HRESET),
    .load     (dph_ld),
    .clr      (dph_clr),
    .ld_write (dph_ld_write),
    .ld_addr  (dph_ld_addr),
    .ld_wdata (dph_ld_wdata),
    .ld_cnt   (dph_ld_cnt),
    .valid    (dph_valid),
    .write    (dph_write),
    .addr     (dph_addr),
    .wdata    (dph_wdata),
    .cnt      (dph_cnt)
  );

  always_comb begin
    state_d      = state_q;
    resp_kind_d  = resp_kind_q;
    reissue_d    = reissue_q;
    rsp_valid_d  = 1'b0;
    rsp_rdata_d  = '0;
    rsp_err_d    = 1'b0;
    aph_ld       = accept;
    aph_clr      = 1'b0;
    dph_ld       = 1'b0;
    dph_clr      = 1'b0;
    dph_ld_write = aph_write;
    dph_ld_addr  = aph_addr;
    dph_ld_wdata = aph_wdata;
    dph_ld_cnt   = aph_cnt;
    case (state_q)
      MST_RUN: begin
        if (HREADY) begin
          // HRESP!=OKAY with HREADY high here is a protocol violation and
          // is deliberately treated as OKAY.
          if (reissue_q) begin
            // Re-issued address phase done; DPH now enters its data phase.
            reissue_d = 1'b0;
          end else begin
            if (dph_valid) begin
              rsp_valid_d = 1'b1;
              rsp_rdata_d = dph_write ? '0 : HRDATA;
            end
            if (aph_valid) begin
              dph_ld  = 1'b1;
              aph_clr = 1'b1;
            end else begin
              dph_clr = 1'b1;
            end
          end
        end else if (HRESP != HRESP_OKAY && dph_valid && !reissue_q) begin
          state_d     = MST_RESP2;
          resp_kind_d = hresp_e'(HRESP);
        end
      end
      MST_RESP2: begin
        if (HREADY) begin
          state_d = MST_RUN;
          if (resp_kind_q == HRESP_ERROR || dph_cnt == CNT_W'(MAX_RETRY)) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            dph_clr     = 1'b1;
          end else begin
            reissue_d    = 1'b1;
            dph_ld       = 1'b1;
            dph_ld_write = dph_write;
            dph_ld_addr  = dph_addr;
            dph_ld_wdata = dph_wdata;
            dph_ld_cnt   = dph_cnt + CNT_W'(1);
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q     <= MST_RUN;
      resp_kind_q <= HRESP_OKAY;
      reissue_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      resp_kind_q <= resp_kind_d;
      reissue_q   <= reissue_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // A re-issue drives the DPH command's address; otherwise APH is driven.
  assign HTRANS = (state_q == MST_RUN && (reissue_q || aph_valid)) ?
                  HTRANS_NONSEQ : HTRANS_IDLE;
  assign HADDR  = reissue_q ? dph_addr  : aph_addr;
  assign HWRITE = reissue_q ? dph_write : aph_write;
  assign HWDATA = dph_wdata;
  assign HSIZE  = HSIZE_WORD;
  assign HBURST = HBURST_SINGLE;

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_ahb_master.sv
module tb_ahb_master;
  import ahb_pkg::*;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic [31:0] HADDR, HWDATA, HRDATA;
  logic [1:0]  HTRANS, HRESP;
  logic        HWRITE, HREADY;
  logic [2:0]  HSIZE, HBURST;

  always #5 HCLK = ~HCLK;

  ahb_master #(.ADDR_W(32), .DATA_W(32), .MAX_RETRY(4)) dut (
    .HCLK(HCLK), .HRESET(HRESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
    .HBURST(HBURST), .HWDATA(HWDATA), .HRDATA(HRDATA), .HREADY(HREADY),
    .HRESP(HRESP)
  );

  typedef struct { logic [31:0] rdata; logic err; } exp_t;
  typedef struct { int waits; logic [1:0] resp; } beh_t;

  exp_t exp_q[$];
  beh_t beh_q[$];

  int checks, failures, cyc, rsp_seen, n20;

  // Bus trace, indexed by the cycle that follows posedge number cyc.
  logic [1:0]  tr_trans [0:4095];
  logic [31:0] tr_addr  [0:4095];
  logic        tr_write [0:4095];
  logic [31:0] tr_wdata [0:4095];
  logic        tr_rdy   [0:4095];
  logic        tr_rsp   [0:4095];

  // Slave model state
  logic [31:0] mem [0:63];
  logic [1:0]  s_trans, s_resp, dp_resp;
  logic [31:0] s_addr, s_wdata, dp_addr;
  logic        s_ready, s_write, dp_act, dp_write, dp_second;
  int          dp_waits;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic push_beh(input int w, input logic [1:0] r);
    beh_t b;
    b.waits = w; b.resp = r;
    beh_q.push_back(b);
  endtask

  // Call just after a posedge. Returns after the accepting edge (+1).
  task automatic send(input logic w, input logic [31:0] a, input logic [31:0] d,
                      input bit track, input logic [31:0] er, input logic e,
                      output int acc);
    bit r;
    int n;
    exp_t x;
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
    n = 0; r = 1'b0;
    forever begin
      @(negedge HCLK); r = cmd_ready;
      @(posedge HCLK);
      if (r) break;
      n++;
      if (n > 60) begin
        chk("accept_timeout", 32'd0, 32'd1);
        break;
      end
    end
    if (track && r) begin
      x.rdata = er; x.err = e;
      exp_q.push_back(x);
    end
    #1;
    cmd_valid = 1'b0;
    acc = cyc;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge HCLK); n++;
    end
    if (exp_q.size() != 0) chk("drain_timeout", exp_q.size(), 0);
    repeat (2) @(posedge HCLK);
    #1;
  endtask

  function automatic int ix(input int i);
    return i & 4095;
  endfunction

  initial begin
    int a0, a1, n0, r0;
    checks = 0; failures = 0; cyc = 0; rsp_seen = 0; n20 = 0;
    dp_act = 0; dp_write = 0; dp_second = 0; dp_waits = 0;
    dp_addr = 0; dp_resp = 0;
    s_trans = 0; s_resp = 0; s_addr = 0; s_wdata = 0; s_ready = 1; s_write = 0;
    HRESET = 1; cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0;
    HREADY = 1; HRESP = HRESP_OKAY; HRDATA = 32'hDEAD_BEEF;
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    mem[5] = 32'h1234_5678;  // 0x14
    mem[8] = 32'hCAFE_F00D;  // 0x20

    fork
      forever begin
        @(posedge HCLK); cyc++;
        if (cyc > 20000) begin
          $display("FAIL watchdog actual=%0d expected<20000", cyc);
          $fatal(1);
        end
      end
      // Trace, slave-side sampling, and the response monitor
      forever begin
        @(negedge HCLK);
        tr_trans[ix(cyc)] = HTRANS; tr_addr[ix(cyc)] = HADDR;
        tr_write[ix(cyc)] = HWRITE; tr_wdata[ix(cyc)] = HWDATA;
        tr_rdy[ix(cyc)] = HREADY;   tr_rsp[ix(cyc)] = rsp_valid;
        s_trans = HTRANS; s_addr = HADDR; s_write = HWRITE;
        s_wdata = HWDATA; s_ready = HREADY; s_resp = HRESP;
        if (rsp_valid === 1'b1) begin
          exp_t e;
          rsp_seen++;
          if (exp_q.size() == 0) begin
            chk("rsp_unexpected", 32'd1, 32'd0);
          end else begin
            e = exp_q.pop_front();
            chk("rsp_rdata", rsp_rdata, e.rdata);
            chk("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
          end
        end
      end
      // Reactive AHB slave
      forever begin
        @(posedge HCLK);
        if (HRESET) begin
          dp_act = 0; dp_second = 0;
        end else begin
          if (dp_act && s_ready) begin
            if (s_resp == HRESP_OKAY && dp_write) mem[dp_addr[7:2]] = s_wdata;
            dp_act = 0;
          end
          if (s_ready && s_trans == HTRANS_NONSEQ) begin
            dp_act = 1; dp_addr = s_addr; dp_write = s_write; dp_second = 0;
            if (beh_q.size() != 0) begin
              beh_t b;
              b = beh_q.pop_front();
              dp_waits = b.waits; dp_resp = b.resp;
            end else begin
              dp_waits = 0; dp_resp = HRESP_OKAY;
            end
            if (s_addr == 32'h20) n20++;
          end
        end
        #1;
        HRDATA = 32'hDEAD_BEEF;
        if (!dp_act) begin
          HREADY = 1; HRESP = HRESP_OKAY;
        end else if (dp_waits > 0) begin
          HREADY = 0; HRESP = HRESP_OKAY; dp_waits--;
        end else if (dp_resp == HRESP_OKAY) begin
          HREADY = 1; HRESP = HRESP_OKAY;
          if (!dp_write) HRDATA = mem[dp_addr[7:2]];
        end else if (!dp_second) begin
          HREADY = 0; HRESP = dp_resp; dp_second = 1;
        end else begin
          HREADY = 1; HRESP = dp_resp;
        end
      end
    join_none

    // Reset values
    repeat (3) @(posedge HCLK);
    @(negedge HCLK);
    chk("rst_htrans", HTRANS, HTRANS_IDLE);
    chk("rst_haddr", HADDR, 0);
    chk("rst_hwrite", HWRITE, 0);
    chk("rst_hwdata", HWDATA, 0);
    chk("rst_hsize", HSIZE, 3'b010);
    chk("rst_hburst", HBURST, 3'b000);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_rsp_err", rsp_err, 0);
    @(posedge HCLK); #1; HRESET = 0;
    @(negedge HCLK);
    chk("rst_cmd_ready", cmd_ready, 1);
    @(posedge HCLK); #1;

    // Back-to-back write then read, zero waits
    send(1, 32'h10, 32'hA5A5_0001, 1, 32'h0, 0, a0);
    send(0, 32'h10, 32'h0, 1, 32'hA5A5_0001, 0, a1);
    drain();
    chk("b2b_accept_gap", a1 - a0, 1);
    chk("b2b_w_trans", tr_trans[ix(a0)], HTRANS_NONSEQ);
    chk("b2b_w_addr", tr_addr[ix(a0)], 32'h10);
    chk("b2b_w_hwrite", tr_write[ix(a0)], 1);
    chk("b2b_r_trans", tr_trans[ix(a1)], HTRANS_NONSEQ);
    chk("b2b_r_hwrite", tr_write[ix(a1)], 0);
    chk("b2b_hwdata", tr_wdata[ix(a1)], 32'hA5A5_0001);
    chk("b2b_rsp1_time", tr_rsp[ix(a0 + 2)], 1);
    chk("b2b_rsp2_time", tr_rsp[ix(a0 + 3)], 1);

    // Three wait states with the next command pipelined in APH
    push_beh(3, HRESP_OKAY);
    send(0, 32'h10, 32'h0, 1, 32'hA5A5_0001, 0, a0);
    send(0, 32'h14, 32'h0, 1, 32'h1234_5678, 0, a1);
    drain();
    chk("wait_trans0", tr_trans[ix(a1)], HTRANS_NONSEQ);
    chk("wait_addr0", tr_addr[ix(a1)], 32'h14);
    chk("wait_trans2", tr_trans[ix(a1 + 2)], HTRANS_NONSEQ);
    chk("wait_addr2", tr_addr[ix(a1 + 2)], 32'h14);
    chk("wait_rdy_low", tr_rdy[ix(a1 + 2)], 0);
    chk("wait_rdy_back", tr_rdy[ix(a1 + 3)], 1);
    chk("wait_no_early_rsp", tr_rsp[ix(a1 + 3)], 0);
    chk("wait_rsp_time", tr_rsp[ix(a1 + 4)], 1);

    // ERROR on a write with a read queued behind it
    push_beh(0, HRESP_ERROR);
    send(1, 32'h30, 32'h0BAD_0BAD, 1, 32'h0, 1, a0);
    send(0, 32'h10, 32'h0, 1, 32'hA5A5_0001, 0, a1);
    drain();
    chk("err_idle", tr_trans[ix(a1 + 1)], HTRANS_IDLE);
    chk("err_redrive_trans", tr_trans[ix(a1 + 2)], HTRANS_NONSEQ);
    chk("err_redrive_addr", tr_addr[ix(a1 + 2)], 32'h10);
    chk("err_rsp_time", tr_rsp[ix(a1 + 2)], 1);
    chk("err_no_mem_write", mem[12], 32'h0);

    // RETRY twice, then OKAY
    n0 = n20;
    push_beh(0, HRESP_RETRY); push_beh(0, HRESP_RETRY); push_beh(0, HRESP_OKAY);
    send(0, 32'h20, 32'h0, 1, 32'hCAFE_F00D, 0, a0);
    drain();
    chk("retry2_issues", n20 - n0, 3);

    // RETRY/SPLIT on every attempt: retries exhausted
    n0 = n20;
    push_beh(0, HRESP_RETRY); push_beh(0, HRESP_SPLIT); push_beh(0, HRESP_RETRY);
    push_beh(0, HRESP_SPLIT); push_beh(0, HRESP_RETRY);
    send(0, 32'h20, 32'h0, 1, 32'h0, 1, a0);
    drain();
    chk("retry_max_issues", n20 - n0, 5);
    chk("retry_beh_left", beh_q.size(), 0);

    // Reset asserted during a data phase
    push_beh(6, HRESP_OKAY);
    send(0, 32'h10, 32'h0, 0, 32'h0, 0, a0);
    send(0, 32'h14, 32'h0, 0, 32'h0, 0, a1);
    @(negedge HCLK);
    chk("pre_rst_haddr", HADDR, 32'h14);
    @(posedge HCLK); #3;
    HRESET = 1;
    #1;
    chk("mid_rst_htrans", HTRANS, HTRANS_IDLE);
    chk("mid_rst_haddr", HADDR, 0);
    chk("mid_rst_hwrite", HWRITE, 0);
    chk("mid_rst_hwdata", HWDATA, 0);
    chk("mid_rst_rsp_valid", rsp_valid, 0);
    r0 = rsp_seen;
    repeat (2) @(posedge HCLK);
    #1; HRESET = 0;
    repeat (6) @(posedge HCLK);
    #1;
    chk("mid_rst_no_rsp", rsp_seen - r0, 0);
    send(1, 32'h18, 32'h5A5A_1818, 1, 32'h0, 0, a0);
    send(0, 32'h18, 32'h0, 1, 32'h5A5A_1818, 0, a1);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
